// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle layout, ALUOp/forwarding encodings, stage FSM states.
package pipe_pkg;

    localparam int CTRL_W          = 9;
    localparam int CTRL_REG_WRITE  = 8;
    localparam int CTRL_MEM_READ   = 7;
    localparam int CTRL_MEM_WRITE  = 6;
    localparam int CTRL_MEM_TO_REG = 5;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_BRANCH     = 3;
    localparam int CTRL_JUMP       = 2;
    localparam int CTRL_ALUOP_LSB  = 0;
    localparam int CTRL_ALUOP_W    = 2;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_IMM    = 2'b11;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_EX   = 2'b10;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } stage_state_e;

    function automatic logic ctrl_mem_read(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEM_READ];
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs and registered EX-side outputs of the ID/EX stage; master = surrounding core, slave = stage.
interface id_ex_stage_if
    import pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic [CTRL_W-1:0] id_ctrl;
    logic              ex_flush;
    logic              mem_stall;

    logic              ID_EX_valid;
    logic [XLEN-1:0]   ID_EX_pc;
    logic [XLEN-1:0]   ID_EX_rs1_data;
    logic [XLEN-1:0]   ID_EX_rs2_data;
    logic [XLEN-1:0]   ID_EX_imm;
    logic [REG_AW-1:0] ID_EX_rs1;
    logic [REG_AW-1:0] ID_EX_rs2;
    logic [REG_AW-1:0] ID_EX_rd;
    logic [CTRL_W-1:0] ID_EX_ctrl;
    logic              pc_write;
    logic              if_id_write;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2, id_ctrl,
               ex_flush, mem_stall,
        input  ID_EX_valid, ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm,
               ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_ctrl, pc_write, if_id_write
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2, id_ctrl,
               ex_flush, mem_stall,
        output ID_EX_valid, ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm,
               ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_ctrl, pc_write, if_id_write
    );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard: the load in EX writes a register the ID instruction actually reads.
// Combinational, no state; also intended for a branch-in-ID hazard path.
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_valid,
    input  logic              id_uses_rs1,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rs2,
    output logic              lu
);
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
    // x0 is never really written, so a load to it cannot create a dependency.
    assign lu = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with one-cycle load-use bubble, EX flush and memory-wait hold.
// Optional HAZARD_PERF_CNT_EN adds bubble/flush event counters.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic        clk,
    input  logic        rst,
    id_ex_stage_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_lu_bubbles,
    output logic [31:0] perf_flushes
`endif
);
    stage_state_e state;
    stage_state_e state_nxt;
    logic         lu;
    logic         lu_hit;
    logic         load_id;
    logic         load_bubble;

    load_use_detect #(.REG_AW(REG_AW)) u_lu (
        .ex_valid    (bus.ID_EX_valid),
        .ex_mem_read (ctrl_mem_read(bus.ID_EX_ctrl)),
        .ex_rd       (bus.ID_EX_rd),
        .id_valid    (bus.id_valid),
        .id_uses_rs1 (bus.id_uses_rs1),
        .id_rs1      (bus.id_rs1),
        .id_uses_rs2 (bus.id_uses_rs2),
        .id_rs2      (bus.id_rs2),
        .lu          (lu)
    );

    // EX already holds a bubble in BUBBLE, so this gate only makes the one-cycle stall explicit.
    assign lu_hit = lu && (state == RUN);

    always_comb begin
        state_nxt       = state;
        bus.pc_write    = 1'b1;
        bus.if_id_write = 1'b1;
        load_id         = 1'b0;
        load_bubble     = 1'b0;
        if (!rst) begin
            if (bus.mem_stall) begin
                bus.pc_write    = 1'b0;
                bus.if_id_write = 1'b0;
            end else if (bus.ex_flush) begin
                load_bubble = 1'b1;
                state_nxt   = RUN;
            end else if (lu_hit) begin
                load_bubble     = 1'b1;
                bus.pc_write    = 1'b0;
                bus.if_id_write = 1'b0;
                state_nxt       = BUBBLE;
            end else begin
                load_id   = 1'b1;
                state_nxt = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || load_bubble) begin
            bus.ID_EX_valid    <= 1'b0;
            bus.ID_EX_pc       <= {XLEN{1'b0}};
            bus.ID_EX_rs1_data <= {XLEN{1'b0}};
            bus.ID_EX_rs2_data <= {XLEN{1'b0}};
            bus.ID_EX_imm      <= {XLEN{1'b0}};
            bus.ID_EX_rs1      <= '0;
            bus.ID_EX_rs2      <= '0;
            bus.ID_EX_rd       <= '0;
            bus.ID_EX_ctrl     <= '0;
        end else if (load_id) begin
            bus.ID_EX_valid    <= bus.id_valid;
            bus.ID_EX_pc       <= bus.id_pc;
            bus.ID_EX_rs1_data <= bus.id_rs1_data;
            bus.ID_EX_rs2_data <= bus.id_rs2_data;
            bus.ID_EX_imm      <= bus.id_imm;
            bus.ID_EX_rs1      <= bus.id_rs1;
            bus.ID_EX_rs2      <= bus.id_rs2;
            bus.ID_EX_rd       <= bus.id_rd;
            bus.ID_EX_ctrl     <= bus.id_ctrl;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic take_flush;
    logic take_lu;

    assign take_flush = !rst && !bus.mem_stall && bus.ex_flush;
    assign take_lu    = !rst && !bus.mem_stall && !bus.ex_flush && lu_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_bubbles <= '0;
            perf_flushes    <= '0;
        end else begin
            if (take_lu)    perf_lu_bubbles <= perf_lu_bubbles + 32'd1;
            if (take_flush) perf_flushes    <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: reset, load-use bubble, x0/no-read cases, flush, stall, back-to-back loads.
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam logic [8:0] C_LW  = 9'h1B0;
    localparam logic [8:0] C_ADD = 9'h102;
    localparam logic [8:0] C_LUI = 9'h113;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    id_ex_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu_bubbles;
    logic [31:0] perf_flushes;
    logic [31:0] lu_base;
`endif

    id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_lu_bubbles (perf_lu_bubbles),
        .perf_flushes    (perf_flushes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [31:0] pc, input logic [31:0] r1d,
                           input logic [31:0] r2d, input logic [31:0] imm,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic u1, input logic u2, input logic [8:0] ctrl);
        bus.id_valid    = v;
        bus.id_pc       = pc;
        bus.id_rs1_data = r1d;
        bus.id_rs2_data = r2d;
        bus.id_imm      = imm;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.id_uses_rs1 = u1;
        bus.id_uses_rs2 = u2;
        bus.id_ctrl     = ctrl;
        #1;
    endtask

    task automatic randomize_id();
        present(1'b1, $urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
                5'($urandom), 1'($urandom), 1'($urandom), 9'($urandom));
        bus.ex_flush = 1'($urandom);
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".valid"}, 64'(bus.ID_EX_valid), 64'd0);
        chk({tag, ".ctrl"},  64'(bus.ID_EX_ctrl),  64'd0);
        chk({tag, ".rd"},    64'(bus.ID_EX_rd),    64'd0);
        chk({tag, ".rs1"},   64'(bus.ID_EX_rs1),   64'd0);
        chk({tag, ".rs2"},   64'(bus.ID_EX_rs2),   64'd0);
        chk({tag, ".pc"},    64'(bus.ID_EX_pc),    64'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // 1. reset with random ID inputs, mem_stall raised in the second cycle
        rst = 1'b1;
        bus.mem_stall = 1'b0;
        randomize_id();
        chk("rst.pc_write", 64'(bus.pc_write), 64'd1);
        tick();
        randomize_id();
        bus.mem_stall = 1'b1;
        #1;
        chk("rst.pc_write_stall", 64'(bus.pc_write), 64'd1);
        chk("rst.if_id_write_stall", 64'(bus.if_id_write), 64'd1);
        tick();
        chk_bubble("rst");
        chk("rst.rs1_data", 64'(bus.ID_EX_rs1_data), 64'd0);
        chk("rst.rs2_data", 64'(bus.ID_EX_rs2_data), 64'd0);
        chk("rst.imm", 64'(bus.ID_EX_imm), 64'd0);
        chk("rst.state", 64'(dut.state), 64'(RUN));
`ifdef HAZARD_PERF_CNT_EN
        chk("rst.perf_lu", 64'(perf_lu_bubbles), 64'd0);
        chk("rst.perf_fl", 64'(perf_flushes), 64'd0);
`endif
        rst = 1'b0;
        bus.mem_stall = 1'b0;
        bus.ex_flush = 1'b0;

        // 2. lw x5,0(x1) ; add x6,x5,x2
        present(1'b1, 32'h100, 32'h1000, 32'h0, 32'h0, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW);
        chk("lu2.lw_no_stall", 64'(bus.pc_write), 64'd1);
        tick();
        chk("lu2.lw_valid", 64'(bus.ID_EX_valid), 64'd1);
        chk("lu2.lw_rd", 64'(bus.ID_EX_rd), 64'd5);
        chk("lu2.lw_ctrl", 64'(bus.ID_EX_ctrl), 64'(C_LW));
        chk("lu2.lw_rs1_data", 64'(bus.ID_EX_rs1_data), 64'h1000);
        present(1'b1, 32'h104, 32'hAAAA, 32'hBBBB, 32'h0, 5'd5, 5'd2, 5'd6, 1'b1, 1'b1, C_ADD);
        chk("lu2.pc_write", 64'(bus.pc_write), 64'd0);
        chk("lu2.if_id_write", 64'(bus.if_id_write), 64'd0);
        tick();
        chk_bubble("lu2.bub");
        chk("lu2.state", 64'(dut.state), 64'(BUBBLE));
        chk("lu2.pc_write_after", 64'(bus.pc_write), 64'd1);
        tick();
        chk("lu2.add_valid", 64'(bus.ID_EX_valid), 64'd1);
        chk("lu2.add_rs1", 64'(bus.ID_EX_rs1), 64'd5);
        chk("lu2.add_rs2", 64'(bus.ID_EX_rs2), 64'd2);
        chk("lu2.add_rd", 64'(bus.ID_EX_rd), 64'd6);
        chk("lu2.add_pc", 64'(bus.ID_EX_pc), 64'h104);
        chk("lu2.add_rs2_data", 64'(bus.ID_EX_rs2_data), 64'hBBBB);

        // 3. load to x0, and a consumer that does not read rs1/rs2
        present(1'b1, 32'h200, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, C_LW);
        tick();
        present(1'b1, 32'h204, 32'h0, 32'h0, 32'h0, 5'd0, 5'd2, 5'd6, 1'b1, 1'b1, C_ADD);
        chk("x0.pc_write", 64'(bus.pc_write), 64'd1);
        chk("x0.if_id_write", 64'(bus.if_id_write), 64'd1);
        tick();
        chk("x0.add_valid", 64'(bus.ID_EX_valid), 64'd1);
        chk("x0.add_rd", 64'(bus.ID_EX_rd), 64'd6);
        present(1'b1, 32'h208, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW);
        tick();
        present(1'b1, 32'h20C, 32'h0, 32'h0, 32'h5000, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, C_LUI);
        chk("lui.pc_write", 64'(bus.pc_write), 64'd1);
        tick();
        chk("lui.valid", 64'(bus.ID_EX_valid), 64'd1);
        chk("lui.ctrl", 64'(bus.ID_EX_ctrl), 64'(C_LUI));
        chk("lui.imm", 64'(bus.ID_EX_imm), 64'h5000);

        // 4. flush coincides with a load-use hazard
        present(1'b1, 32'h300, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW);
        tick();
        present(1'b1, 32'h304, 32'h0, 32'h0, 32'h0, 5'd5, 5'd2, 5'd6, 1'b1, 1'b1, C_ADD);
        bus.ex_flush = 1'b1;
        #1;
        chk("fl.pc_write", 64'(bus.pc_write), 64'd1);
        tick();
        bus.ex_flush = 1'b0;
        chk_bubble("fl.bub");
        chk("fl.state", 64'(dut.state), 64'(RUN));
`ifdef HAZARD_PERF_CNT_EN
        chk("fl.perf_fl", 64'(perf_flushes), 64'd1);
        chk("fl.perf_lu", 64'(perf_lu_bubbles), 64'd1);
`endif
        present(1'b1, 32'h400, 32'h0, 32'h0, 32'h0, 5'd5, 5'd2, 5'd6, 1'b1, 1'b1, C_ADD);
        tick();
        chk("fl.next_valid", 64'(bus.ID_EX_valid), 64'd1);
        chk("fl.next_pc", 64'(bus.ID_EX_pc), 64'h400);

        // 5. mem_stall for 3 cycles while in BUBBLE
        present(1'b1, 32'h500, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW);
        tick();
        present(1'b1, 32'h504, 32'h0, 32'h0, 32'h0, 5'd5, 5'd2, 5'd6, 1'b1, 1'b1, C_ADD);
        tick();
        chk("st.state0", 64'(dut.state), 64'(BUBBLE));
        bus.mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st.pc_write", 64'(bus.pc_write), 64'd0);
            chk("st.if_id_write", 64'(bus.if_id_write), 64'd0);
            tick();
            chk("st.valid", 64'(bus.ID_EX_valid), 64'd0);
            chk("st.rd", 64'(bus.ID_EX_rd), 64'd0);
            chk("st.state", 64'(dut.state), 64'(BUBBLE));
        end
        bus.mem_stall = 1'b0;
        tick();
        chk("st.add_valid", 64'(bus.ID_EX_valid), 64'd1);
        chk("st.add_rs1", 64'(bus.ID_EX_rs1), 64'd5);
        chk("st.add_pc", 64'(bus.ID_EX_pc), 64'h504);
        chk("st.state_run", 64'(dut.state), 64'(RUN));
        // stall with a live instruction in EX: new ID data must not load
        present(1'b1, 32'h508, 32'h0, 32'h0, 32'h0, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, C_ADD);
        bus.mem_stall = 1'b1;
        tick();
        chk("st.hold_pc", 64'(bus.ID_EX_pc), 64'h504);
        chk("st.hold_rd", 64'(bus.ID_EX_rd), 64'd6);
        bus.mem_stall = 1'b0;
        tick();
        chk("st.release_pc", 64'(bus.ID_EX_pc), 64'h508);

        // 6. back-to-back independent loads, then a dependent add
`ifdef HAZARD_PERF_CNT_EN
        lu_base = perf_lu_bubbles;
`endif
        present(1'b1, 32'h600, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, C_LW);
        tick();
        present(1'b1, 32'h604, 32'h0, 32'h0, 32'h4, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0, C_LW);
        chk("bb.lw2_pc_write", 64'(bus.pc_write), 64'd1);
        tick();
        chk("bb.lw2_rd", 64'(bus.ID_EX_rd), 64'd4);
        present(1'b1, 32'h608, 32'h0, 32'h0, 32'h8, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, C_LW);
        chk("bb.lw3_pc_write", 64'(bus.pc_write), 64'd1);
        tick();
        present(1'b1, 32'h60C, 32'h0, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, C_ADD);
        chk("bb.add_pc_write", 64'(bus.pc_write), 64'd0);
        tick();
        chk_bubble("bb.bub");
        tick();
        chk("bb.add_rd", 64'(bus.ID_EX_rd), 64'd7);
        chk("bb.add_valid", 64'(bus.ID_EX_valid), 64'd1);
`ifdef HAZARD_PERF_CNT_EN
        chk("bb.perf_lu_delta", 64'(perf_lu_bubbles - lu_base), 64'd1);
        chk("bb.perf_lu_total", 64'(perf_lu_bubbles), 64'd3);
`endif

        // reset from BUBBLE returns to RUN with cleared outputs
        present(1'b1, 32'h700, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW);
        tick();
        present(1'b1, 32'h704, 32'h0, 32'h0, 32'h0, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, C_ADD);
        tick();
        rst = 1'b1;
        tick();
        chk("rst2.state", 64'(dut.state), 64'(RUN));
        chk_bubble("rst2");
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
